// File: rtl/isr_pipe_ctrl.sv
// isr_pipe_ctrl: handshaked integer square root, one root bit per cycle.
// Restoring digit-by-digit method: two operand bits enter the partial
// remainder each cycle and one root bit is decided. No multipliers.
// Returns floor(sqrt(value)) and the remainder value - root^2.
module isr_pipe_ctrl #(
    parameter  int WIDTH  = 64,
    localparam int ROOT_W = WIDTH / 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_value,
    output logic              in_ready,
    output logic              out_valid,
    output logic [ROOT_W-1:0] out_root,
    output logic [ROOT_W:0]   out_rem,
    input  logic              out_ready,
    output logic              busy
);

    // The remainder needs two spare bits: the shifted remainder and the trial
    // value both reach ROOT_W+2 bits on the last iteration.
    localparam int REM_W = ROOT_W + 2;
    localparam int CNT_W = $clog2(ROOT_W);
    localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(ROOT_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   op;
    logic [ROOT_W-1:0]  q;
    logic [REM_W-1:0]   r;
    logic [CNT_W-1:0]   cnt;

    logic [REM_W-1:0]   r_sh;
    logic [REM_W-1:0]   trial;
    logic [REM_W-1:0]   r_nxt;
    logic [ROOT_W-1:0]  q_nxt;
    logic               r_top_unused;

    // The stored remainder never exceeds 2*q, so its top two bits are always
    // zero before the shift; they are dropped when the next pair enters.
    assign r_top_unused = ^r[REM_W-1:REM_W-2];

    // In DONE a new operand can be taken only on the edge that retires the
    // current result, so readiness follows the consumer, not the producer.
    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);

    // One restoring iteration: bring in the next operand pair, try (q<<2)|1.
    always_comb begin
        r_sh  = {r[REM_W-3:0], op[WIDTH-1 -: 2]};
        trial = {q, 2'b01};
        r_nxt = r_sh;
        q_nxt = {q[ROOT_W-2:0], 1'b0};
        if (r_sh >= trial) begin
            r_nxt = r_sh - trial;
            q_nxt = {q[ROOT_W-2:0], 1'b1};
        end
    end

    // Control FSM with registered outputs; datapath registers load on accept/iterate.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_root  <= '0;
            out_rem   <= '0;
            busy      <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op    <= in_value;
                        q     <= '0;
                        r     <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    op  <= op << 2;
                    q   <= q_nxt;
                    r   <= r_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_IT) begin
                        out_root  <= q_nxt;
                        out_rem   <= r_nxt[ROOT_W:0];
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            // Retire and accept on the same edge: no bubble.
                            op    <= in_value;
                            q     <= '0;
                            r     <= '0;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= CALC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_isr_pipe_ctrl.sv
// Bench for isr_pipe_ctrl: a 64-bit and a 16-bit instance, scoreboard of
// expected root/remainder pushed at accept and popped at output handshake.
module tb_isr_pipe_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b0;

    logic        in_valid64  = 1'b0;
    logic [63:0] in_value64  = '0;
    logic        in_ready64;
    logic        out_valid64;
    logic [31:0] out_root64;
    logic [32:0] out_rem64;
    logic        out_ready64 = 1'b0;
    logic        busy64;

    logic        in_valid16  = 1'b0;
    logic [15:0] in_value16  = '0;
    logic        in_ready16;
    logic        out_valid16;
    logic [7:0]  out_root16;
    logic [8:0]  out_rem16;
    logic        out_ready16 = 1'b0;
    logic        busy16;

    int compared = 0;
    int mism     = 0;
    int cyc      = 0;

    logic [127:0] q64[$];
    logic [127:0] q16[$];
    int           l64[$];
    int           l16[$];
    logic         acc64 = 1'b0, acc16 = 1'b0;
    logic         prev_ov64 = 1'b0, prev_ov16 = 1'b0;

    isr_pipe_ctrl #(.WIDTH(64)) dut64 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid64), .in_value(in_value64), .in_ready(in_ready64),
        .out_valid(out_valid64), .out_root(out_root64), .out_rem(out_rem64),
        .out_ready(out_ready64), .busy(busy64)
    );

    isr_pipe_ctrl #(.WIDTH(16)) dut16 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid16), .in_value(in_value16), .in_ready(in_ready16),
        .out_valid(out_valid16), .out_root(out_root16), .out_rem(out_rem16),
        .out_ready(out_ready16), .busy(busy16)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: greedy bit-by-bit search using real squaring.
    function automatic logic [127:0] model(input logic [63:0] v);
        logic [31:0] rt;
        logic [31:0] c;
        logic [63:0] sq;
        rt = '0;
        for (int b = 31; b >= 0; b--) begin
            c  = rt | (32'd1 << b);
            sq = {32'd0, c} * {32'd0, c};
            if (sq <= v) rt = c;
        end
        sq = {32'd0, rt} * {32'd0, rt};
        return {32'd0, rt, v - sq};
    endfunction

    // 64-bit monitor: latency on rising out_valid, results on handshake, push on accept.
    always @(negedge clock) begin
        logic [127:0] e;
        if (!reset) begin
            q64.delete(); l64.delete();
            acc64 = 1'b0; prev_ov64 = 1'b0;
        end else begin
            acc64 = in_valid64 && in_ready64;
            if (out_valid64 && !prev_ov64) begin
                chk("lat64_pending", 64'(l64.size() != 0), 64'd1);
                if (l64.size() != 0) chk("lat64", 64'(cyc - l64.pop_front()), 64'd32);
            end
            if (out_valid64 && out_ready64) begin
                chk("sb64_pending", 64'(q64.size() != 0), 64'd1);
                if (q64.size() != 0) begin
                    e = q64.pop_front();
                    chk("root64", {32'd0, out_root64}, e[127:64]);
                    chk("rem64", {31'd0, out_rem64}, e[63:0]);
                end
            end
            if (acc64) begin
                q64.push_back(model(in_value64));
                l64.push_back(cyc + 1);
            end
            prev_ov64 = out_valid64;
        end
    end

    // 16-bit monitor, same scheme with an 8-cycle latency.
    always @(negedge clock) begin
        logic [127:0] e;
        if (!reset) begin
            q16.delete(); l16.delete();
            acc16 = 1'b0; prev_ov16 = 1'b0;
        end else begin
            acc16 = in_valid16 && in_ready16;
            if (out_valid16 && !prev_ov16) begin
                chk("lat16_pending", 64'(l16.size() != 0), 64'd1);
                if (l16.size() != 0) chk("lat16", 64'(cyc - l16.pop_front()), 64'd8);
            end
            if (out_valid16 && out_ready16) begin
                chk("sb16_pending", 64'(q16.size() != 0), 64'd1);
                if (q16.size() != 0) begin
                    e = q16.pop_front();
                    chk("root16", {56'd0, out_root16}, e[127:64]);
                    chk("rem16", {55'd0, out_rem16}, e[63:0]);
                end
            end
            if (acc16) begin
                q16.push_back(model({48'd0, in_value16}));
                l16.push_back(cyc + 1);
            end
            prev_ov16 = out_valid16;
        end
    end

    task automatic send64(input logic [63:0] v);
        int n = 0;
        in_valid64 = 1'b1; in_value64 = v;
        do begin @(posedge clock); #1; n++; end while (!acc64 && n < 200);
        chk("accept64", 64'(acc64), 64'd1);
        in_valid64 = 1'b0;
    endtask

    task automatic send16(input logic [15:0] v);
        int n = 0;
        in_valid16 = 1'b1; in_value16 = v;
        do begin @(posedge clock); #1; n++; end while (!acc16 && n < 200);
        chk("accept16", 64'(acc16), 64'd1);
        in_valid16 = 1'b0;
    endtask

    task automatic drain64();
        int n = 0;
        out_ready64 = 1'b1;
        while ((q64.size() != 0 || out_valid64) && n < 200) begin @(posedge clock); #1; n++; end
        chk("drain64", 64'(q64.size()), 64'd0);
    endtask

    task automatic drain16();
        int n = 0;
        out_ready16 = 1'b1;
        while ((q16.size() != 0 || out_valid16) && n < 200) begin @(posedge clock); #1; n++; end
        chk("drain16", 64'(q16.size()), 64'd0);
    endtask

    function automatic logic [63:0] rv64();
        logic [63:0] v;
        v = {$urandom, $urandom};
        return v >> $urandom_range(0, 63);
    endfunction

    task automatic rand64(input int n);
        int sent = 0, guard = 0;
        in_value64 = rv64(); in_valid64 = 1'b1;
        while (sent < n && guard < n * 100) begin
            @(posedge clock); #1; guard++;
            out_ready64 = ($urandom_range(0, 3) != 0);
            if (acc64) begin
                sent++;
                if (sent < n) in_value64 = rv64(); else in_valid64 = 1'b0;
            end
        end
        chk("rand64_sent", 64'(sent), 64'(n));
        in_valid64 = 1'b0;
        drain64();
    endtask

    task automatic rand16(input int n);
        int sent = 0, guard = 0;
        in_value16 = 16'($urandom_range(0, 65535)); in_valid16 = 1'b1;
        while (sent < n && guard < n * 40) begin
            @(posedge clock); #1; guard++;
            out_ready16 = ($urandom_range(0, 2) != 0);
            if (acc16) begin
                sent++;
                if (sent < n) in_value16 = 16'($urandom_range(0, 65535)); else in_valid16 = 1'b0;
            end
        end
        chk("rand16_sent", 64'(sent), 64'(n));
        in_valid16 = 1'b0;
        drain16();
    endtask

    initial begin
        // Reset, then check the first cycle after release.
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        chk("rst_in_ready64", 64'(in_ready64), 64'd1);
        chk("rst_out_valid64", 64'(out_valid64), 64'd0);
        chk("rst_root64", {32'd0, out_root64}, 64'd0);
        chk("rst_rem64", {31'd0, out_rem64}, 64'd0);
        chk("rst_busy64", 64'(busy64), 64'd0);
        chk("rst_in_ready16", 64'(in_ready16), 64'd1);
        chk("rst_out_valid16", 64'(out_valid16), 64'd0);

        // Directed values with the consumer always ready.
        out_ready64 = 1'b1;
        send64(64'd1001); drain64();
        send64(64'd25);   drain64();
        send64(64'd26);   drain64();
        send64(64'd0);    drain64();
        send64(64'd1);    drain64();
        send64(64'hFFFF_FFFF_FFFF_FFFF); drain64();
        send64(64'h4000_0000_0000_0000); drain64();

        // Backpressure: hold the result for ten cycles.
        out_ready64 = 1'b0;
        send64(64'd1001);
        for (int n = 0; n < 100 && !out_valid64; n++) begin @(posedge clock); #1; end
        chk("bp_arrive", 64'(out_valid64), 64'd1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 64'(out_valid64), 64'd1);
            chk("bp_root", {32'd0, out_root64}, 64'd31);
            chk("bp_rem", {31'd0, out_rem64}, 64'd40);
            chk("bp_in_ready", 64'(in_ready64), 64'd0);
            @(posedge clock); #1;
        end
        // Release together with a new operand: retire and accept on one edge.
        out_ready64 = 1'b1;
        send64(64'd144);
        chk("b2b_busy", 64'(busy64), 64'd1);
        chk("b2b_out_valid", 64'(out_valid64), 64'd0);
        drain64();

        // Reset during iteration 10 discards the operation.
        send64(64'd1001);
        repeat (9) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock); #1;
        chk("mid_rst_busy", 64'(busy64), 64'd0);
        chk("mid_rst_out_valid", 64'(out_valid64), 64'd0);
        chk("mid_rst_root", {32'd0, out_root64}, 64'd0);
        chk("mid_rst_rem", {31'd0, out_rem64}, 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready64), 64'd1);
        reset = 1'b1;
        repeat (40) @(posedge clock);
        #1;
        chk("mid_rst_no_stale", 64'(out_valid64), 64'd0);

        // 16-bit instance.
        out_ready16 = 1'b1;
        send16(16'd65535); drain16();
        send16(16'd100);   drain16();

        // Random operands with random consumer stalls.
        rand16(1500);
        rand64(200);

        repeat (5) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
